// File: rtl/game_state_ctrl.sv
// Raccoon crossing game sequencer: gates raccoon movement, requests respawns
// and keeps lives, level and score. Every output comes straight from a flop.
module game_state_ctrl #(
  parameter int c_LIVES        = 3,
  parameter int c_GOAL_Y       = 0,
  parameter int c_HIT_DELAY    = 25000000,
  parameter int c_CLEAR_DELAY  = 12500000,
  parameter int c_FLASH_PERIOD = 3125000,
  parameter int c_MAX_LEVEL    = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic [9:0] i_Raccoon_Y,
  output logic       o_Move_En,
  output logic       o_Respawn,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [7:0] o_Score,
  output logic [2:0] o_State,
  output logic       o_Hit_Flash
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    CLEAR = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [31:0] HIT_LAST   = 32'(c_HIT_DELAY - 1);
  localparam logic [31:0] CLEAR_LAST = 32'(c_CLEAR_DELAY - 1);
  localparam logic [31:0] FLASH_LAST = 32'(c_FLASH_PERIOD - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(c_LIVES);
  localparam logic [2:0]  LEVEL_MAX  = 3'(c_MAX_LEVEL);
  localparam logic [9:0]  GOAL_Y     = 10'(c_GOAL_Y);

  state_t      r_State, w_Next;
  logic        r_Start_d;
  logic [31:0] r_Timer, r_Flash_Cnt;
  logic        r_Flash, r_Move_En, r_Respawn;
  logic [1:0]  r_Lives, w_Lives;
  logic [2:0]  r_Level, w_Level;
  logic [7:0]  r_Score, w_Score;
  logic        w_Respawn, w_Start_Rise;

  assign w_Start_Rise = i_Start & ~r_Start_d;

  // Contract with the position controller: o_Move_En is a level permission,
  // o_Respawn is a single-cycle request coinciding with the first PLAY cycle.
  always_comb begin
    w_Next    = r_State;
    w_Lives   = r_Lives;
    w_Level   = r_Level;
    w_Score   = r_Score;
    w_Respawn = 1'b0;
    case (r_State)
      IDLE, OVER: begin
        if (w_Start_Rise) begin
          w_Next    = PLAY;
          w_Lives   = LIVES_INIT;
          w_Level   = 3'd0;
          w_Score   = 8'd0;
          w_Respawn = 1'b1;
        end
      end
      PLAY: begin
        if (i_Collision) begin
          w_Next  = HIT;
          w_Lives = (r_Lives == 2'd0) ? 2'd0 : r_Lives - 2'd1;
        end else if (!r_Respawn && i_Raccoon_Y == GOAL_Y) begin
          // Y is stale during the respawn cycle, so the goal is skipped there.
          w_Next  = CLEAR;
          w_Score = (r_Score == 8'd255) ? 8'd255 : r_Score + 8'd1;
        end
      end
      HIT: begin
        if (r_Timer == HIT_LAST) begin
          if (r_Lives == 2'd0) begin
            w_Next = OVER;
          end else begin
            w_Next    = PLAY;
            w_Respawn = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (r_Timer == CLEAR_LAST) begin
          w_Next    = PLAY;
          w_Respawn = 1'b1;
          w_Level   = (r_Level >= LEVEL_MAX) ? LEVEL_MAX : r_Level + 3'd1;
        end
      end
      default: w_Next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= IDLE;
      r_Start_d   <= 1'b1;
      r_Timer     <= 32'd0;
      r_Flash_Cnt <= 32'd0;
      r_Flash     <= 1'b0;
      r_Move_En   <= 1'b0;
      r_Respawn   <= 1'b0;
      r_Lives     <= LIVES_INIT;
      r_Level     <= 3'd0;
      r_Score     <= 8'd0;
    end else begin
      r_State   <= w_Next;
      r_Start_d <= i_Start;
      r_Timer   <= (w_Next != r_State) ? 32'd0 : r_Timer + 32'd1;
      r_Move_En <= (w_Next == PLAY);
      r_Respawn <= w_Respawn;
      r_Lives   <= w_Lives;
      r_Level   <= w_Level;
      r_Score   <= w_Score;
      if (w_Next == HIT && r_State != HIT) begin
        r_Flash_Cnt <= 32'd0;
        r_Flash     <= 1'b1;
      end else if (w_Next == HIT) begin
        if (r_Flash_Cnt == FLASH_LAST) begin
          r_Flash_Cnt <= 32'd0;
          r_Flash     <= ~r_Flash;
        end else begin
          r_Flash_Cnt <= r_Flash_Cnt + 32'd1;
        end
      end else begin
        r_Flash_Cnt <= 32'd0;
        r_Flash     <= 1'b0;
      end
    end
  end

  assign o_State     = r_State;
  assign o_Move_En   = r_Move_En;
  assign o_Respawn   = r_Respawn;
  assign o_Lives     = r_Lives;
  assign o_Level     = r_Level;
  assign o_Score     = r_Score;
  assign o_Hit_Flash = r_Flash;

endmodule
